// File: rtl/simon_pkg.sv
// Shared sizing defaults and controller state encodings for the Simon game.
// Imported by the datapath, the controller and the benches.
package simon_pkg;

    localparam int SIMON_WIDTH = 4;
    localparam int SIMON_DEPTH = 64;

    typedef enum logic [1:0] {
        ST_INPUT    = 2'd0,
        ST_PLAYBACK = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_DONE     = 2'd3
    } simon_state_t;

endpackage

// File: rtl/simon_pattern_mem.sv
// Pattern store: DEPTH x WIDTH array, write on the rising edge, asynchronous read.
// Contents are not reset; a same-address read during a write returns the old entry.
module simon_pattern_mem #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simon_datapath.sv
// Simon datapath: sequence/playback counters, level latch, pattern memory and status flags.
// Flags are combinational from inputs and state; counters and memory update one edge after their strobes.
module simon_datapath
    import simon_pkg::*;
#(
    parameter int WIDTH = SIMON_WIDTH,
    parameter int DEPTH = SIMON_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lvl,
    input  logic [WIDTH-1:0] pattern,
    input  logic             seq_ctr_inc,
    input  logic             pbrd_ctr_inc,
    input  logic             led,
    input  logic             wr,
    output logic             cont,
    output logic             correct,
    output logic             legal,
    output logic [WIDTH-1:0] pattern_leds
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0] seq_cnt;
    logic [CNT_W-1:0] pbrd_cnt;
    logic             level_r;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] last_idx;
    logic             one_hot;
    logic             mem_we;

    assign full     = (seq_cnt == FULL_CNT);
    assign empty    = (seq_cnt == '0);
    assign last_idx = seq_cnt - CNT_W'(1);
    // Gating with rst keeps a reset cycle from landing a stray write.
    assign mem_we   = wr && !full && rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            seq_cnt  <= '0;
            pbrd_cnt <= '0;
            level_r  <= lvl;
        end else begin
            if (seq_ctr_inc && !full) begin
                seq_cnt <= seq_cnt + CNT_W'(1);
            end
            if (pbrd_ctr_inc) begin
                if (empty || (pbrd_cnt == last_idx)) begin
                    pbrd_cnt <= '0;
                end else begin
                    pbrd_cnt <= pbrd_cnt + CNT_W'(1);
                end
            end
        end
    end

    simon_pattern_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (seq_cnt[ADDR_W-1:0]),
        .wdata (pattern),
        .raddr (pbrd_cnt[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    assign one_hot = (pattern != '0) && ((pattern & (pattern - WIDTH'(1))) == '0);

    always_comb begin
        legal = 1'b0;
        if (!full) begin
            legal = level_r ? (pattern != '0) : one_hot;
        end
    end

    assign cont         = !empty && (pbrd_cnt != last_idx);
    assign correct      = (pattern == rd_data);
    assign pattern_leds = led ? rd_data : pattern;

endmodule

// File: tb/tb_simon_datapath.sv
// Directed bench for simon_datapath (DEPTH=4); stimulus queues expectations, a negedge monitor checks them.
module tb_simon_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic       lvl;
    logic [3:0] pattern;
    logic       seq_ctr_inc;
    logic       pbrd_ctr_inc;
    logic       led;
    logic       wr;
    logic       cont;
    logic       correct;
    logic       legal;
    logic [3:0] pattern_leds;

    simon_datapath #(.WIDTH(4), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .lvl          (lvl),
        .pattern      (pattern),
        .seq_ctr_inc  (seq_ctr_inc),
        .pbrd_ctr_inc (pbrd_ctr_inc),
        .led          (led),
        .wr           (wr),
        .cont         (cont),
        .correct      (correct),
        .legal        (legal),
        .pattern_leds (pattern_leds)
    );

    always #5 clk = ~clk;

    localparam int S_LEGAL = 0, S_CONT = 1, S_CORRECT = 2, S_LEDS = 3, S_SEQ = 4, S_PBRD = 5;

    typedef struct packed {
        int         cyc;
        int         sig;
        logic [7:0] val;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(int sig);
        case (sig)
            S_LEGAL:   return {7'd0, legal};
            S_CONT:    return {7'd0, cont};
            S_CORRECT: return {7'd0, correct};
            S_LEDS:    return {4'd0, pattern_leds};
            S_SEQ:     return 8'(dut.seq_cnt);
            S_PBRD:    return 8'(dut.pbrd_cnt);
            default:   return 8'hxx;
        endcase
    endfunction

    task automatic expect_val(int sig, logic [7:0] v, string name);
        exp_t e;
        e.cyc = cyc;
        e.sig = sig;
        e.val = v;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic drv(logic [3:0] p, logic w, logic si, logic pi, logic l);
        pattern      = p;
        wr           = w;
        seq_ctr_inc  = si;
        pbrd_ctr_inc = pi;
        led          = l;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst(logic l);
        rst = 1'b0;
        lvl = l;
        drv(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt();
        rst = 1'b1;
        lvl = ~l;
    endtask

    task automatic wr_entry(logic [3:0] p);
        drv(p, 1'b1, 1'b1, 1'b0, 1'b0);
        nxt();
    endtask

    exp_t       mon_e;
    string      mon_n;
    logic [7:0] mon_a;

    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            mon_a = actual(mon_e.sig);
            total = total + 1;
            if (mon_a !== mon_e.val) begin
                bad = bad + 1;
                $display("FAIL %s: got %0h want %0h", mon_n, mon_a, mon_e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        lvl = 1'b0;
        drv(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt();

        // Easy level
        rst = 1'b1;
        expect_val(S_SEQ, 8'd0, "rst_seq");
        expect_val(S_PBRD, 8'd0, "rst_pbrd");
        expect_val(S_CONT, 8'd0, "rst_cont");
        pattern = 4'b0011; expect_val(S_LEGAL, 8'd0, "easy_0011"); nxt();
        pattern = 4'b0100; expect_val(S_LEGAL, 8'd1, "easy_0100"); nxt();
        pattern = 4'b0000; expect_val(S_LEGAL, 8'd0, "easy_0000"); lvl = 1'b1; nxt();
        pattern = 4'b0011; expect_val(S_LEGAL, 8'd0, "easy_lvl_ignored_0011"); nxt();
        pattern = 4'b1000; expect_val(S_LEGAL, 8'd1, "easy_lvl_ignored_1000"); nxt();

        // Hard level, lvl dropped after reset
        do_rst(1'b1);
        pattern = 4'b0000; expect_val(S_LEGAL, 8'd0, "hard_0000"); nxt();
        pattern = 4'b1011; expect_val(S_LEGAL, 8'd1, "hard_1011"); nxt();
        pattern = 4'b0011; expect_val(S_LEGAL, 8'd1, "hard_lvl_ignored_0011"); nxt();

        // Playback strobe with nothing stored leaves the pointer at 0
        drv(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_val(S_CONT, 8'd0, "empty_cont");
        nxt();
        drv(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_val(S_PBRD, 8'd0, "empty_pbrd_stays");
        expect_val(S_SEQ, 8'd0, "empty_seq");
        nxt();

        // First entry
        do_rst(1'b0);
        drv(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_val(S_SEQ, 8'd0, "first_pre_seq");
        expect_val(S_LEGAL, 8'd1, "first_legal");
        nxt();
        drv(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_val(S_SEQ, 8'd1, "first_seq");
        expect_val(S_PBRD, 8'd0, "first_pbrd");
        expect_val(S_CONT, 8'd0, "first_cont");
        expect_val(S_LEDS, 8'h4, "first_leds_mem");
        nxt();
        drv(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_val(S_LEDS, 8'h1, "first_leds_sw");
        expect_val(S_CORRECT, 8'd0, "first_correct_miss");
        nxt();

        // Playback wrap over three entries
        do_rst(1'b0);
        wr_entry(4'b0001);
        wr_entry(4'b0010);
        wr_entry(4'b1000);
        drv(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_val(S_SEQ, 8'd3, "pb_seq");
        expect_val(S_PBRD, 8'd0, "pb0_pbrd");
        expect_val(S_CONT, 8'd1, "pb0_cont");
        expect_val(S_LEDS, 8'h1, "pb0_leds");
        nxt();
        expect_val(S_PBRD, 8'd1, "pb1_pbrd");
        expect_val(S_CONT, 8'd1, "pb1_cont");
        expect_val(S_LEDS, 8'h2, "pb1_leds");
        nxt();
        expect_val(S_PBRD, 8'd2, "pb2_pbrd");
        expect_val(S_CONT, 8'd0, "pb2_cont");
        expect_val(S_LEDS, 8'h8, "pb2_leds");
        nxt();
        drv(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_val(S_PBRD, 8'd0, "pb_wrap_pbrd");
        expect_val(S_CONT, 8'd1, "pb_wrap_cont");
        expect_val(S_LEDS, 8'h1, "pb_wrap_leds");
        nxt();

        // Repeat compare
        drv(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        nxt();
        drv(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_val(S_PBRD, 8'd1, "rep_pbrd1");
        expect_val(S_CORRECT, 8'd1, "rep1_hit");
        nxt();
        drv(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_val(S_CORRECT, 8'd0, "rep1_miss");
        nxt();
        drv(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_val(S_PBRD, 8'd2, "rep_pbrd2");
        expect_val(S_CORRECT, 8'd1, "rep2_hit");
        expect_val(S_CONT, 8'd0, "rep2_cont");
        nxt();
        drv(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_val(S_CORRECT, 8'd0, "rep2_miss");
        nxt();

        // Fill to DEPTH; mem[0] still holds 0001 from the previous game
        do_rst(1'b0);
        drv(4'b0100, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_val(S_LEDS, 8'h1, "wr_rd_same_addr_old");
        nxt();
        drv(4'b0010, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_val(S_LEDS, 8'h4, "wr_rd_same_addr_new");
        nxt();
        wr_entry(4'b1000);
        wr_entry(4'b0001);
        drv(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_val(S_SEQ, 8'd4, "full_seq");
        expect_val(S_LEGAL, 8'd0, "full_legal");
        nxt();
        drv(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);
        nxt();
        drv(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_val(S_SEQ, 8'd4, "full_seq_sat");
        expect_val(S_LEDS, 8'h4, "full_mem0");
        expect_val(S_CONT, 8'd1, "full_cont0");
        nxt();
        expect_val(S_LEDS, 8'h2, "full_mem1");
        expect_val(S_CONT, 8'd1, "full_cont1");
        nxt();
        expect_val(S_LEDS, 8'h8, "full_mem2");
        expect_val(S_CONT, 8'd1, "full_cont2");
        nxt();
        expect_val(S_LEDS, 8'h1, "full_mem3");
        expect_val(S_CONT, 8'd0, "full_cont3");
        nxt();
        expect_val(S_PBRD, 8'd0, "full_wrap_pbrd");
        nxt();
        nxt();

        // Reset mid-playback with every strobe active
        expect_val(S_PBRD, 8'd2, "mid_pbrd");
        rst = 1'b0;
        drv(4'b0001, 1'b1, 1'b1, 1'b1, 1'b1);
        nxt();
        rst = 1'b1;
        drv(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_val(S_SEQ, 8'd0, "mid_rst_seq");
        expect_val(S_PBRD, 8'd0, "mid_rst_pbrd");
        expect_val(S_CONT, 8'd0, "mid_rst_cont");
        expect_val(S_LEDS, 8'h4, "mid_rst_mem_kept");
        expect_val(S_LEGAL, 8'd1, "mid_rst_legal");
        nxt();

        nxt();
        nxt();
        if (exp_q.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL leftover: got %0d unchecked want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simon_datapath.md
Name: simon_datapath

Overview:
- Datapath partner of the Simon control FSM. Executes its control strobes (seq_ctr_inc, pbrd_ctr_inc, led, wr) and returns the status flags (continue, correct, legal) that drive its state transitions.
- Holds the pattern memory, the sequence-length counter and the playback/repeat counter, plus the legality and compare logic.
- Drives the four game pattern LEDs.

Parameters:
- WIDTH, 4, bits per pattern (one switch/LED per bit)
- DEPTH, 64, maximum stored sequence length
- Derived locally: ADDR_W = clog2(DEPTH), CNT_W = ADDR_W+1

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk
- lvl  input  1  difficulty select, sampled only while rst=0
- pattern  input  WIDTH  player switch pattern
- seq_ctr_inc  input  1  increment sequence-length counter
- pbrd_ctr_inc  input  1  advance playback/repeat counter
- led  input  1  1 = LEDs show memory, 0 = LEDs show pattern input
- wr  input  1  write pattern into memory at current sequence length
- continue  output  1  playback/repeat pointer not on last stored entry
- correct  output  1  pattern equals stored entry at playback pointer
- legal  output  1  pattern acceptable for entry under latched level
- pattern_leds  output  WIDTH  displayed pattern

Behaviour:
- Reset (rst=0 at clk edge):
  - seq_cnt<=0, pbrd_cnt<=0, level_r<=lvl.
  - Memory contents are not cleared; entries at index >= seq_cnt are undefined.
  - Reset mid-operation discards the game immediately, with no partial write.
- level_r is held constant between resets; lvl changes outside reset are ignored.
- legal is combinational:
  - level_r=0 (easy): pattern is exactly one-hot.
  - level_r=1 (hard): pattern != 0.
  - Forced to 0 when seq_cnt == DEPTH (memory full).
- Write: if wr=1 and seq_cnt < DEPTH, mem[seq_cnt] <= pattern at clk edge. wr is ignored when full.
- Sequence counter:
  - seq_ctr_inc=1 and seq_cnt < DEPTH -> seq_cnt <= seq_cnt+1.
  - Saturates at DEPTH, never wraps.
- wr and seq_ctr_inc in the same cycle: write uses the pre-increment seq_cnt, so the new entry lands at the old length. This is the controller's normal case.
- Playback counter, on pbrd_ctr_inc=1:
  - pbrd_cnt == seq_cnt-1 -> pbrd_cnt <= 0 (wrap).
  - Otherwise pbrd_cnt <= pbrd_cnt+1.
  - If seq_cnt == 0, pbrd_cnt stays 0.
- continue is combinational: (seq_cnt != 0) && (pbrd_cnt != seq_cnt-1).
  - The controller sees continue=0 on the last entry.
  - Its concurrent pbrd_ctr_inc wraps pbrd_cnt to 0 for the next phase.
- Memory read: combinational (asynchronous) at pbrd_cnt, rd_data = mem[pbrd_cnt].
  - A write and a read at the same address in the same cycle returns the old data; new data is visible from the next cycle.
- correct is combinational: (pattern == rd_data).
  - Meaningful only when seq_cnt > 0; the controller never consults it otherwise.
- pattern_leds is combinational: led ? rd_data : pattern.
- Timing:
  - All flags respond in the same cycle as their inputs, with zero latency. The controller's next-state logic depends on this.
  - Counters and memory update one edge after their strobes.
- Strobes arriving simultaneously are handled independently; no strobe blocks another.

Decomposition:
- simon_pkg holds:
  - WIDTH and DEPTH defaults.
  - The controller state encodings (INPUT=0, PLAYBACK=1, REPEAT=2, DONE=3), so benches and the top level share them.
- Sub-module simon_pattern_mem:
  - DEPTH x WIDTH array.
  - Synchronous write (we, waddr, wdata), asynchronous read (raddr, rdata).
  - No reset.
- Counters, level latch and flag logic stay in simon_datapath.

Test Plan:
- Easy-mode legality: rst=0 with lvl=0, then rst=1. pattern=0011 -> legal=0; 0100 -> legal=1; 0000 -> legal=0. Raise lvl=1 after reset -> legality unchanged.
- Hard-mode legality: rst=0 with lvl=1. pattern=0000 -> legal=0; 1011 -> legal=1.
- First entry: pattern=0100 with wr=seq_ctr_inc=1 for one cycle -> seq_cnt=1, pbrd_cnt=0, continue=0. With led=1 -> pattern_leds=0100; led=0, pattern=0001 -> pattern_leds=0001.
- Playback wrap: write 0001, 0010, 1000 (seq_cnt=3). Pulse pbrd_ctr_inc three times -> continue before each pulse is 1,1,0; pattern_leds shows 0001,0010,1000; pbrd_cnt returns to 0.
- Repeat compare: same 3-entry memory at pbrd_cnt=1. pattern=0010 -> correct=1; pattern=0100 -> correct=0; a pbrd_ctr_inc pulse moves the compare to entry 2 (1000).
- Full and reset: DEPTH=4, write 4 legal entries -> seq_cnt=4, legal=0 for pattern=0001; a further wr does not alter mem[0..3]. Then rst=0 for one cycle mid-playback -> seq_cnt=0, pbrd_cnt=0, continue=0.
